// File: rtl/data_mem_if.sv
// data_mem_if: CPU data-bus signals between the core (master) and the memory responder (slave).
interface data_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output read, write, address, wdata, input rdata, rvalid);
  modport slave  (input read, write, address, wdata, output rdata, rvalid);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus MMIO window (LEDS, SWITCHES, TIMER, SCRATCH/COMPARE), registered reads.
// Define DMEM_TIMER_IRQ_EN to make offset +3 a timer COMPARE register that drives irq.
module data_mem_responder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MMIO_BASE = 2**ADDR_W - 4
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus,
  output logic       req_err,
  output logic [7:0] leds,
  input  logic [7:0] switches,
  output logic       irq
);
  localparam logic [ADDR_W-1:0] MMIO_BASE_A = ADDR_W'(MMIO_BASE);

  logic [DATA_W-1:0] ram [MMIO_BASE];
  logic [DATA_W-1:0] rdata_q, rdata_d, timer_q, timer_d, aux_q, aux_d, rd_sel;
  logic              rvalid_q, rvalid_d, req_err_q, req_err_d, irq_q, irq_d;
  logic [7:0]        leds_q, leds_d, sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic              is_mmio, rd_en, ram_we, mmio_we;
  logic [1:0]        mmio_off;

  always_comb begin
    is_mmio  = (bus.address >= MMIO_BASE_A);
    mmio_off = 2'(bus.address - MMIO_BASE_A);
    // A simultaneous read+write performs only the write.
    rd_en    = bus.read & ~bus.write;
    ram_we   = bus.write & ~is_mmio & ~rst;
    mmio_we  = bus.write & is_mmio;

    if (is_mmio) begin
      unique case (mmio_off)
        2'd0:    rd_sel = DATA_W'(leds_q);
        2'd1:    rd_sel = DATA_W'(sw_sync_q);
        2'd2:    rd_sel = timer_q;
        default: rd_sel = aux_q;
      endcase
    end else begin
      rd_sel = ram[bus.address];
    end

    rvalid_d  = rd_en;
    rdata_d   = rd_en ? rd_sel : rdata_q;
    req_err_d = req_err_q | (bus.read & bus.write);
    sw_meta_d = switches;
    sw_sync_d = sw_meta_q;
    leds_d    = leds_q;
    aux_d     = aux_q;
    timer_d   = timer_q + DATA_W'(1);

    // A TIMER write counts as the load plus that edge's increment.
    if (mmio_we) begin
      unique case (mmio_off)
        2'd0:    leds_d  = bus.wdata[7:0];
        2'd1:    ;
        2'd2:    timer_d = bus.wdata + DATA_W'(1);
        default: aux_d   = bus.wdata;
      endcase
    end

`ifdef DMEM_TIMER_IRQ_EN
    irq_d = irq_q | (timer_q == aux_q);
    if (mmio_we && mmio_off == 2'd3) irq_d = 1'b0;
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[bus.address] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      req_err_q <= 1'b0;
      leds_q    <= '0;
      irq_q     <= 1'b0;
      timer_q   <= '0;
      aux_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      req_err_q <= req_err_d;
      leds_q    <= leds_d;
      irq_q     <= irq_d;
      timer_q   <= timer_d;
      aux_q     <= aux_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign req_err    = req_err_q;
  assign leds       = leds_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed + randomized checks of data_mem_responder against a cycle-indexed reference model.
module tb_data_mem_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] leds;
  logic [7:0] sw_drv = 8'h00;
  logic       req_err;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  data_mem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  data_mem_responder #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .req_err  (req_err),
    .leds     (leds),
    .switches (sw_drv),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model: RAM as a sparse map, timer as (load value, load edge) plus elapsed edges,
  // switches as a per-edge history read two edges late.
  logic [31:0] ref_mem [int];
  int          wr_addrs [$];
  logic [7:0]  sw_hist [int];
  int          cyc = 0;
  int          t_load_cyc = 0;
  logic [31:0] t_load = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_aux = '0;
  logic [7:0]  m_leds = '0;
  logic        m_rvalid = 1'b0;
  logic        m_err = 1'b0;
  logic        m_irq = 1'b0;

  function automatic void model_edge(logic r, logic w, logic [7:0] a, logic [31:0] d);
    logic [31:0] tnow;
    cyc++;
    tnow = t_load + 32'(cyc - 1 - t_load_cyc);
    sw_hist[cyc] = sw_drv;
    if (rst) begin
      sw_hist[cyc] = '0;
      sw_hist[cyc-1] = '0;
      t_load = '0; t_load_cyc = cyc;
      m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0; m_leds = '0; m_aux = '0; m_irq = 1'b0;
      return;
    end
    m_rvalid = r && !w;
    if (m_rvalid) begin
      if (a < 8'd252) m_rdata = ref_mem[int'(a)];
      else if (a == 8'd252) m_rdata = {24'd0, m_leds};
      else if (a == 8'd253) m_rdata = {24'd0, sw_hist[cyc-2]};
      else if (a == 8'd254) m_rdata = tnow;
      else m_rdata = m_aux;
    end
`ifdef DMEM_TIMER_IRQ_EN
    if (tnow == m_aux) m_irq = 1'b1;
`endif
    if (r && w) m_err = 1'b1;
    if (w) begin
      if (a < 8'd252) begin
        if (!ref_mem.exists(int'(a))) wr_addrs.push_back(int'(a));
        ref_mem[int'(a)] = d;
      end else if (a == 8'd252) m_leds = d[7:0];
      else if (a == 8'd254) begin t_load = d + 32'd1; t_load_cyc = cyc; end
      else if (a == 8'd255) begin
        m_aux = d;
`ifdef DMEM_TIMER_IRQ_EN
        m_irq = 1'b0;
`endif
      end
    end
  endfunction

  task automatic tick(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus.read = r; bus.write = w; bus.address = a; bus.wdata = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus.rvalid, bus.rdata, req_err, leds, irq} !== {1'b0, 32'h0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rvalid=%b rdata=%h req_err=%b leds=%h irq=%b, want all zero",
               bus.rvalid, bus.rdata, req_err, leds, irq);
    end
  endtask

  task automatic test_write_read();
    tick(1'b0, 1'b1, 8'h05, 32'h12345678);
    n_vec++;
    if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL write_no_rvalid: got %b want 0", bus.rvalid); end
    tick(1'b1, 1'b0, 8'h05, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h12345678}) begin
      n_err++; $display("FAIL read_0x05: got rvalid=%b rdata=%h want 1/12345678", bus.rvalid, bus.rdata);
    end
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b0, 32'h12345678}) begin
      n_err++; $display("FAIL rvalid_drop_hold: got rvalid=%b rdata=%h want 0/12345678", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b1, 8'h10, 32'h000000A5);
    tick(1'b1, 1'b0, 8'h10, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hA5}) begin
      n_err++; $display("FAIL raw_no_stale: got rvalid=%b rdata=%h want 1/000000a5", bus.rvalid, bus.rdata);
    end
    tick(1'b1, 1'b0, 8'h05, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h12345678}) begin
      n_err++; $display("FAIL b2b_first: got rvalid=%b rdata=%h want 1/12345678", bus.rvalid, bus.rdata);
    end
    tick(1'b1, 1'b0, 8'h10, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hA5}) begin
      n_err++; $display("FAIL b2b_second: got rvalid=%b rdata=%h want 1/000000a5", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_mmio_io();
    tick(1'b0, 1'b1, 8'hFC, 32'h000001FF);
    n_vec++;
    if (leds !== 8'hFF) begin n_err++; $display("FAIL leds_write: got %h want ff", leds); end
    tick(1'b1, 1'b0, 8'hFC, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hFF}) begin
      n_err++; $display("FAIL leds_read: got rvalid=%b rdata=%h want 1/000000ff", bus.rvalid, bus.rdata);
    end
    sw_drv = 8'h3C;
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    tick(1'b1, 1'b0, 8'hFD, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h3C}) begin
      n_err++; $display("FAIL switches_read: got rvalid=%b rdata=%h want 1/0000003c", bus.rvalid, bus.rdata);
    end
    tick(1'b0, 1'b1, 8'hFD, 32'h00000055);
    tick(1'b1, 1'b0, 8'hFD, 32'h0);
    n_vec++;
    if (bus.rdata !== 32'h3C) begin n_err++; $display("FAIL switches_ro: got %h want 0000003c", bus.rdata); end
    // A change one edge before the read must not be visible yet.
    sw_drv = 8'hC3;
    tick(1'b1, 1'b0, 8'hFD, 32'h0);
    n_vec++;
    if (bus.rdata !== 32'h3C) begin n_err++; $display("FAIL switches_sync_delay: got %h want 0000003c", bus.rdata); end
  endtask

  task automatic test_timer_wrap();
    tick(1'b0, 1'b1, 8'hFE, 32'hFFFFFFFE);
    tick(1'b1, 1'b0, 8'hFE, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hFFFFFFFF}) begin
      n_err++; $display("FAIL timer_pre_wrap: got rvalid=%b rdata=%h want 1/ffffffff", bus.rvalid, bus.rdata);
    end
    tick(1'b1, 1'b0, 8'hFE, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL timer_wrap: got rvalid=%b rdata=%h want 1/00000000", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_aux();
`ifdef DMEM_TIMER_IRQ_EN
    bit seen = 1'b0;
    tick(1'b0, 1'b1, 8'hFF, 32'd50);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear_on_cmp_write: got %b want 0", irq); end
    tick(1'b0, 1'b1, 8'hFE, 32'd40);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 8'h00, 32'h0);
      n_vec++;
      if (irq !== m_irq) begin n_err++; $display("FAIL irq_track[%0d]: got %b want %b", i, irq, m_irq); end
      if (irq === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || irq !== 1'b1) begin n_err++; $display("FAIL irq_sticky: got %b want 1", irq); end
    tick(1'b0, 1'b1, 8'hFF, 32'd1000);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b want 0", irq); end
`else
    tick(1'b0, 1'b1, 8'hFF, 32'h0000DEAD);
    tick(1'b1, 1'b0, 8'hFF, 32'h0);
    n_vec++;
    if ({bus.rvalid, bus.rdata, irq} !== {1'b1, 32'hDEAD, 1'b0}) begin
      n_err++; $display("FAIL scratch_rw: got rvalid=%b rdata=%h irq=%b want 1/0000dead/0", bus.rvalid, bus.rdata, irq);
    end
`endif
  endtask

  task automatic test_conflict();
    tick(1'b1, 1'b1, 8'h20, 32'h00000077);
    n_vec++;
    if ({bus.rvalid, req_err} !== 2'b01) begin
      n_err++; $display("FAIL conflict: got rvalid=%b req_err=%b want 0/1", bus.rvalid, req_err);
    end
    tick(1'b1, 1'b0, 8'h20, 32'h0);
    tick(1'b0, 1'b0, 8'h00, 32'h0);
    n_vec++;
    if ({bus.rdata, req_err} !== {32'h77, 1'b1}) begin
      n_err++; $display("FAIL conflict_write_sticky: got rdata=%h req_err=%b want 00000077/1", bus.rdata, req_err);
    end
    rst = 1'b1;
    tick(1'b1, 1'b0, 8'h20, 32'h0);
    rst = 1'b0;
    n_vec++;
    if ({bus.rvalid, req_err, bus.rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_overrides_read: got rvalid=%b req_err=%b rdata=%h want 0/0/0", bus.rvalid, req_err, bus.rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int unsigned kind = $urandom_range(0, 9);
      logic [7:0]  a = 8'($urandom_range(0, 251));
      logic [31:0] d = $urandom();
      if ($urandom_range(0, 7) == 0) sw_drv = 8'($urandom());
      if (kind <= 3) tick(1'b0, 1'b1, a, d);
      else if (kind <= 6) begin
        a = 8'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
        tick(1'b1, 1'b0, a, 32'h0);
      end
      else if (kind == 7) tick(1'b1, 1'b0, 8'(252 + $urandom_range(0, 3)), 32'h0);
      else if (kind == 8) tick(1'b0, 1'b1, 8'(252 + $urandom_range(0, 3)), d);
      else tick(1'b0, 1'b0, a, d);
      n_vec++;
      if ({bus.rvalid, bus.rdata, leds, req_err, irq} !== {m_rvalid, m_rdata, m_leds, m_err, m_irq}) begin
        n_err++;
        $display("FAIL random[%0d]: got rvalid=%b rdata=%h leds=%h req_err=%b irq=%b want %b/%h/%h/%b/%b",
                 i, bus.rvalid, bus.rdata, leds, req_err, irq, m_rvalid, m_rdata, m_leds, m_err, m_irq);
      end
    end
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.wdata = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_mmio_io();
    test_timer_wrap();
    test_aux();
    test_conflict();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
